// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1x2 stream demux.
package demux_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W     = 4;

    typedef enum logic {
        EXPECT_L0 = 1'b0,
        EXPECT_L1 = 1'b1
    } phase_e;

endpackage

// File: rtl/demux_1x2_4b.sv
// Rebuilds lane-0/lane-1 pairs from a valid-qualified serial stream.
module demux_1x2_4b
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             valid_input,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_output,
    output logic [CNT_W-1:0] pair_count,
    output logic             phase
);

    phase_e             r_state;
    logic [WIDTH-1:0]   r_hold;
    logic [WIDTH-1:0]   r_out0;
    logic [WIDTH-1:0]   r_out1;
    logic               r_valid;
    logic [CNT_W-1:0]   r_count;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= EXPECT_L0;
            r_hold  <= '0;
            r_out0  <= '0;
            r_out1  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_valid <= 1'b0;
            // Idle cycles freeze everything; data_in is ignored.
            if (valid_input) begin
                unique case (r_state)
                    EXPECT_L0: begin
                        r_hold  <= data_in;
                        r_state <= EXPECT_L1;
                    end
                    EXPECT_L1: begin
                        r_out0  <= r_hold;
                        r_out1  <= data_in;
                        r_valid <= 1'b1;
                        r_count <= r_count + 1'b1;
                        r_state <= EXPECT_L0;
                    end
                    default: r_state <= EXPECT_L0;
                endcase
            end
        end
    end

    assign data_out0    = r_out0;
    assign data_out1    = r_out1;
    assign valid_output = r_valid;
    assign pair_count   = r_count;
    assign phase        = r_state;

endmodule

// File: tb/tb_demux_1x2_4b.sv
// Directed + random bench for demux_1x2_4b against a queue-based pair model.
module tb_demux_1x2_4b;

    logic       clk;
    logic       reset_L;
    logic       valid_input;
    logic [3:0] data_in;
    logic [3:0] data_out0;
    logic [3:0] data_out1;
    logic       valid_output;
    logic [3:0] pair_count;
    logic       phase;

    int n_vec;
    int n_bad;
    int pulses;

    logic [3:0] q[$];
    logic [3:0] m_out0;
    logic [3:0] m_out1;
    logic       m_valid;
    int         m_pairs;

    demux_1x2_4b #(.WIDTH(4)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .valid_input  (valid_input),
        .data_in      (data_in),
        .data_out0    (data_out0),
        .data_out1    (data_out1),
        .valid_output (valid_output),
        .pair_count   (pair_count),
        .phase        (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_out0  = '0;
        m_out1  = '0;
        m_valid = 1'b0;
        m_pairs = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out0"}, {4'h0, data_out0}, {4'h0, m_out0});
        chk({tag, ".out1"}, {4'h0, data_out1}, {4'h0, m_out1});
        chk({tag, ".vout"}, {7'h0, valid_output}, {7'h0, m_valid});
        chk({tag, ".cnt"}, {4'h0, pair_count}, 8'(m_pairs % 16));
        chk({tag, ".phase"}, {7'h0, phase}, {7'h0, q.size() == 1});
    endtask

    // Caller sits at a negedge; one word (or idle) is applied for one edge.
    task automatic step(input logic v, input logic [3:0] d, input string tag);
        valid_input = v;
        data_in     = d;
        @(posedge clk);
        m_valid = 1'b0;
        if (v) begin
            q.push_back(d);
            if (q.size() == 2) begin
                m_out0  = q.pop_front();
                m_out1  = q.pop_front();
                m_valid = 1'b1;
                m_pairs++;
            end
        end
        #1;
        if (valid_output) pulses++;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        valid_input = 1'b0;
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        pulses = 0;
        model_reset();
        reset_L     = 1'b0;
        valid_input = 1'b0;
        data_in     = 4'hF;
        repeat (3) @(negedge clk);
        check_all("reset");
        reset_L = 1'b1;

        step(1'b1, 4'd1, "s1");
        step(1'b1, 4'd2, "s2");
        chk("pair1.out0", {4'h0, data_out0}, 8'd1);
        chk("pair1.out1", {4'h0, data_out1}, 8'd2);
        chk("pair1.vout", {7'h0, valid_output}, 8'd1);
        step(1'b1, 4'd3, "s3");
        chk("pair1.drop", {7'h0, valid_output}, 8'd0);
        step(1'b1, 4'd4, "s4");
        chk("pair2.out0", {4'h0, data_out0}, 8'd3);
        chk("pair2.out1", {4'h0, data_out1}, 8'd4);
        chk("pair2.cnt", {4'h0, pair_count}, 8'd2);

        step(1'b1, 4'hA, "gapA");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'($urandom), "gap");
            chk("gap.phase", {7'h0, phase}, 8'd1);
        end
        step(1'b1, 4'd5, "gap5");
        chk("gap.out0", {4'h0, data_out0}, 8'hA);
        chk("gap.out1", {4'h0, data_out1}, 8'd5);

        for (int i = 0; i < 10; i++)
            step(1'b0, 4'($urandom), "noise");

        step(1'b1, 4'd9, "mid9");
        async_reset("midrst");
        step(1'b1, 4'd6, "s6");
        step(1'b1, 4'd7, "s7");
        chk("rst.out0", {4'h0, data_out0}, 8'd6);
        chk("rst.out1", {4'h0, data_out1}, 8'd7);

        async_reset("wraprst");
        pulses = 0;
        for (int i = 0; i < 32; i++)
            step(1'b1, 4'($urandom), "wrap");
        chk("wrap.cnt", {4'h0, pair_count}, 8'd0);
        chk("wrap.pulses", 8'(pulses), 8'd16);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0)
                async_reset("rndrst");
            step(1'($urandom_range(0, 2) != 0), 4'($urandom), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
